// File: rtl/vl_uart_mon_pkg.sv
// Shared definitions for the UART console monitor: FSM states, parity modes,
// oversampling constants and the parity helper.
package vl_uart_mon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } uart_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  localparam int OVRSAMP    = 16;
  localparam int MID_SAMPLE = 8;

  // Unused upper bits must be zero so they do not disturb the XOR reduction.
  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    logic p;
    p = ^data;
    return (mode == PARITY_ODD) ? ~p : p;
  endfunction

endpackage

// File: rtl/vl_uart_mon_fifo.sv
// Synchronous first-word-fall-through FIFO; pointers carry one extra bit so
// full and empty are distinguished without a separate counter.
module vl_uart_mon_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  // Head is forced to zero while empty so the output is defined after reset.
  assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/vl_uart_monitor.sv
// UART console monitor: synchroniser, 16x tick generator, deframing FSM,
// error counting and output FIFO. Define VL_UART_MON_DISPLAY_EN for console printing.
module vl_uart_monitor
  import vl_uart_mon_pkg::*;
#(
  parameter int         DATA_BITS  = 8,
  parameter int         PARITY     = 0,
  parameter int         STOP_BITS  = 1,
  parameter int         DIV        = 27,
  parameter int         FIFO_DEPTH = 16,
  parameter logic [7:0] END_CODE   = 8'hFF
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_vld,
  input  logic                 data_rdy,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 ovf_err,
  output logic [15:0]          err_cnt,
  output logic                 end_seen,
  output uart_state_t          o_dbg_state
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic                 r_rxd_meta, r_rxd_sync, r_rxd_prev;
  logic [DIV_W-1:0]     r_div_cnt;
  logic [3:0]           r_os_cnt;
  logic [2:0]           r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift, r_char;
  logic                 r_par_bad, r_stop_bad;
  logic                 r_push_req, r_frame_err, r_parity_err, r_end_seen;
  logic [15:0]          r_err_cnt;
  uart_state_t          r_state;

  logic w_fall, w_tick, w_mid, w_end;
  logic w_stop_bad, w_last_stop, w_par_bad, w_is_end;
  logic w_full, w_empty, w_pop, w_push, w_ovf, w_err_any;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_rxd_meta <= 1'b1;
      r_rxd_sync <= 1'b1;
      r_rxd_prev <= 1'b1;
    end else begin
      r_rxd_meta <= rxd;
      r_rxd_sync <= r_rxd_meta;
      r_rxd_prev <= r_rxd_sync;
    end
  end

  assign w_fall      = r_rxd_prev & ~r_rxd_sync;
  assign w_tick      = (r_div_cnt == DIV_W'(DIV - 1));
  assign w_mid       = w_tick && (r_os_cnt == 4'(MID_SAMPLE - 1));
  assign w_end       = w_tick && (r_os_cnt == 4'(OVRSAMP - 1));
  assign w_stop_bad  = r_stop_bad | ~r_rxd_sync;
  assign w_last_stop = (r_bit_cnt == 3'(STOP_BITS - 1));
  assign w_par_bad   = r_rxd_sync != parity_bit(8'(r_shift), PARITY);
  assign w_is_end    = (r_shift == END_CODE[DATA_BITS-1:0]);

  // Bits are sampled on the 8th tick; the final stop bit resolves the character
  // at its sample point so the next start edge is never missed.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state      <= ST_IDLE;
      r_div_cnt    <= '0;
      r_os_cnt     <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_char       <= '0;
      r_par_bad    <= 1'b0;
      r_stop_bad   <= 1'b0;
      r_push_req   <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_end_seen   <= 1'b0;
    end else begin
      r_push_req   <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      if (r_state == ST_IDLE || w_tick) r_div_cnt <= '0;
      else                              r_div_cnt <= r_div_cnt + DIV_W'(1);
      if (r_state != ST_IDLE && w_tick) r_os_cnt <= r_os_cnt + 4'd1;
      case (r_state)
        ST_IDLE: begin
          if (w_fall) begin
            r_state    <= ST_START;
            r_os_cnt   <= '0;
            r_par_bad  <= 1'b0;
            r_stop_bad <= 1'b0;
          end
        end
        ST_START: begin
          if (w_mid && r_rxd_sync) begin
            r_state <= ST_IDLE;
          end else if (w_end) begin
            r_state   <= ST_DATA;
            r_bit_cnt <= '0;
          end
        end
        ST_DATA: begin
          if (w_mid) r_shift <= {r_rxd_sync, r_shift[DATA_BITS-1:1]};
          if (w_end) begin
            if (r_bit_cnt == 3'(DATA_BITS - 1)) begin
              r_state   <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
              r_bit_cnt <= '0;
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end
        end
        ST_PARITY: begin
          if (w_mid) r_par_bad <= w_par_bad;
          if (w_end) r_state <= ST_STOP;
        end
        ST_STOP: begin
          if (w_mid) begin
            r_stop_bad <= w_stop_bad;
            if (w_last_stop) begin
              r_state <= ST_IDLE;
              if (w_stop_bad) begin
                r_frame_err <= 1'b1;
                if (!r_rxd_sync) r_state <= ST_BREAK;
              end else if (r_par_bad) begin
                r_parity_err <= 1'b1;
              end else if (w_is_end) begin
                r_end_seen <= 1'b1;
              end else begin
                r_push_req <= 1'b1;
                r_char     <= r_shift;
              end
            end
          end else if (w_end) begin
            r_bit_cnt <= r_bit_cnt + 3'd1;
          end
        end
        ST_BREAK: begin
          if (r_rxd_sync) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_pop     = ~w_empty & data_rdy;
  assign w_push    = r_push_req & (~w_full | w_pop);
  assign w_ovf     = r_push_req & w_full & ~w_pop;
  assign w_err_any = r_frame_err | r_parity_err | w_ovf;

  always_ff @(posedge clk) begin
    if (!nrst)                               r_err_cnt <= '0;
    else if (w_err_any && r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
  end

  vl_uart_mon_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .nrst    (nrst),
    .i_push  (w_push),
    .i_data  (r_char),
    .i_pop   (w_pop),
    .o_data  (data_out),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign data_vld    = ~w_empty;
  assign frame_err   = r_frame_err;
  assign parity_err  = r_parity_err;
  assign ovf_err     = w_ovf;
  assign err_cnt     = r_err_cnt;
  assign end_seen    = r_end_seen;
  assign o_dbg_state = r_state;

`ifdef VL_UART_MON_DISPLAY_EN
  always @(posedge clk) begin
    if (nrst) begin
      if (w_pop)        $write("%c", data_out);
      if (r_frame_err)  $display("\n[vl_uart_monitor] framing error");
      if (r_parity_err) $display("\n[vl_uart_monitor] parity error");
      if (w_ovf)        $display("\n[vl_uart_monitor] fifo overflow, character dropped");
      if (r_end_seen && w_empty) $finish;
    end
  end
`else
`endif

endmodule

// File: tb/tb_vl_uart_monitor.sv
// Bench for vl_uart_monitor: an 8N1 instance (A) and a 7E2 instance (B), driven
// with directed and random frames and checked against a frame-level model.
module tb_vl_uart_monitor;
  import vl_uart_mon_pkg::*;

  localparam int DIV_TB   = 4;
  localparam int BIT_CLKS = 16 * DIV_TB;
  localparam int DEPTH_A  = 16;
  localparam int DEPTH_B  = 4;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        rxd_a = 1'b1, rxd_b = 1'b1;
  logic        rdy_a = 1'b1, rdy_b = 1'b1;
  logic [7:0]  dout_a;
  logic [6:0]  dout_b;
  logic        vld_a, vld_b, ferr_a, ferr_b, perr_a, perr_b, oerr_a, oerr_b;
  logic        end_a, end_b;
  logic [15:0] ecnt_a, ecnt_b;
  uart_state_t dbg_a, dbg_b;

  always #5 clk = ~clk;

  vl_uart_monitor #(
    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .DIV(DIV_TB), .FIFO_DEPTH(DEPTH_A), .END_CODE(8'hFF)
  ) u_dut_a (
    .clk(clk), .nrst(nrst), .rxd(rxd_a), .data_out(dout_a), .data_vld(vld_a), .data_rdy(rdy_a),
    .frame_err(ferr_a), .parity_err(perr_a), .ovf_err(oerr_a), .err_cnt(ecnt_a),
    .end_seen(end_a), .o_dbg_state(dbg_a)
  );

  vl_uart_monitor #(
    .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .DIV(DIV_TB), .FIFO_DEPTH(DEPTH_B), .END_CODE(8'hFF)
  ) u_dut_b (
    .clk(clk), .nrst(nrst), .rxd(rxd_b), .data_out(dout_b), .data_vld(vld_b), .data_rdy(rdy_b),
    .frame_err(ferr_b), .parity_err(perr_b), .ovf_err(oerr_b), .err_cnt(ecnt_b),
    .end_seen(end_b), .o_dbg_state(dbg_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_q_a[$];
  logic [7:0] exp_q_b[$];
  int exp_frame[2], exp_par[2], exp_ovf[2];
  int obs_frame[2], obs_par[2], obs_ovf[2];
  bit exp_end[2];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every pop is compared against the oldest predicted character.
  always @(negedge clk) begin
    if (nrst) begin
      obs_frame[0] += int'(ferr_a); obs_par[0] += int'(perr_a); obs_ovf[0] += int'(oerr_a);
      obs_frame[1] += int'(ferr_b); obs_par[1] += int'(perr_b); obs_ovf[1] += int'(oerr_b);
      if (vld_a && rdy_a) begin
        check_val("a_pop_expected", 32'(exp_q_a.size() != 0), 32'd1);
        if (exp_q_a.size() != 0) check_val("a_data", 32'(dout_a), 32'(exp_q_a.pop_front()));
      end
      if (vld_b && rdy_b) begin
        check_val("b_pop_expected", 32'(exp_q_b.size() != 0), 32'd1);
        if (exp_q_b.size() != 0) check_val("b_data", 32'(dout_b), 32'(exp_q_b.pop_front()));
      end
    end
  end

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input int w, input logic v);
    if (w == 0) rxd_a = v;
    else        rxd_b = v;
  endtask

  // Frame-level model: decides the fate of a character from its framing alone.
  task automatic predict(input int w, input logic [7:0] data, input bit par_flip, input logic [1:0] stops);
    logic [7:0] mask, d;
    bit stop_ok;
    int depth, qsize;
    mask    = (w == 0) ? 8'hFF : 8'h7F;
    d       = data & mask;
    stop_ok = (w == 0) ? stops[0] : (stops[0] && stops[1]);
    depth   = (w == 0) ? DEPTH_A : DEPTH_B;
    qsize   = (w == 0) ? exp_q_a.size() : exp_q_b.size();
    if (!stop_ok)                  exp_frame[w]++;
    else if (w == 1 && par_flip)   exp_par[w]++;
    else if (d == (8'hFF & mask))  exp_end[w] = 1'b1;
    else if (qsize == depth)       exp_ovf[w]++;
    else if (w == 0)               exp_q_a.push_back(d);
    else                           exp_q_b.push_back(d);
  endtask

  task automatic send_frame(input int w, input logic [7:0] data, input bit par_flip, input logic [1:0] stops);
    int dbits, nstop, ones;
    logic par;
    dbits = (w == 0) ? 8 : 7;
    nstop = (w == 0) ? 1 : 2;
    predict(w, data, par_flip, stops);
    drive(w, 1'b0); hold(BIT_CLKS);
    for (int i = 0; i < dbits; i++) begin
      drive(w, data[i]); hold(BIT_CLKS);
    end
    if (w == 1) begin
      ones = $countones(data & 8'h7F);
      par  = ((ones % 2) == 1) ? 1'b1 : 1'b0;
      drive(w, par ^ par_flip); hold(BIT_CLKS);
    end
    for (int i = 0; i < nstop; i++) begin
      drive(w, stops[i]); hold(BIT_CLKS);
    end
    drive(w, 1'b1); hold(2 * BIT_CLKS);
  endtask

  task automatic checkpoint(input int w, input string tag);
    hold(40);
    check_val({tag, "_frame_err"},  32'(obs_frame[w]), 32'(exp_frame[w]));
    check_val({tag, "_parity_err"}, 32'(obs_par[w]),   32'(exp_par[w]));
    check_val({tag, "_ovf_err"},    32'(obs_ovf[w]),   32'(exp_ovf[w]));
    if (w == 0) begin
      check_val({tag, "_err_cnt"},  32'(ecnt_a), 32'(exp_frame[0] + exp_par[0] + exp_ovf[0]));
      check_val({tag, "_end_seen"}, 32'(end_a),  32'(exp_end[0]));
      check_val({tag, "_data_vld"}, 32'(vld_a),  32'(exp_q_a.size() != 0));
    end else begin
      check_val({tag, "_err_cnt"},  32'(ecnt_b), 32'(exp_frame[1] + exp_par[1] + exp_ovf[1]));
      check_val({tag, "_end_seen"}, 32'(end_b),  32'(exp_end[1]));
      check_val({tag, "_data_vld"}, 32'(vld_b),  32'(exp_q_b.size() != 0));
    end
  endtask

  task automatic clear_model();
    exp_q_a.delete();
    exp_q_b.delete();
    for (int i = 0; i < 2; i++) begin
      exp_frame[i] = 0; exp_par[i] = 0; exp_ovf[i] = 0; exp_end[i] = 1'b0;
      obs_frame[i] = 0; obs_par[i] = 0; obs_ovf[i] = 0;
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_data_out"}, 32'(dout_a), 32'd0);
    check_val({tag, "_data_vld"}, 32'(vld_a),  32'd0);
    check_val({tag, "_pulses"},   32'({ferr_a, perr_a, oerr_a, ferr_b, perr_b, oerr_b}), 32'd0);
    check_val({tag, "_err_cnt"},  32'(ecnt_a) + 32'(ecnt_b), 32'd0);
    check_val({tag, "_end_seen"}, 32'({end_a, end_b}), 32'd0);
    check_val({tag, "_state"},    32'({dbg_a, dbg_b}), 32'({ST_IDLE, ST_IDLE}));
  endtask

  initial begin
    clear_model();
    hold(3);
    check_reset_state("rst");
    nrst = 1'b1;
    hold(4);

    send_frame(0, 8'h41, 1'b0, 2'b11);
    checkpoint(0, "a_0x41");

    send_frame(0, 8'h55, 1'b0, 2'b10);
    send_frame(0, 8'h0A, 1'b0, 2'b11);
    checkpoint(0, "a_frame_err");

    send_frame(1, 8'h03, 1'b1, 2'b11);
    checkpoint(1, "b_par_bad");
    send_frame(1, 8'h03, 1'b0, 2'b11);
    checkpoint(1, "b_par_ok");

    rdy_a = 1'b0;
    for (int i = 0; i <= 16; i++) send_frame(0, 8'(i), 1'b0, 2'b11);
    checkpoint(0, "a_full");
    rdy_a = 1'b1;
    checkpoint(0, "a_drain");

    drive(0, 1'b0); hold(5 * DIV_TB); drive(0, 1'b1); hold(2 * BIT_CLKS);
    checkpoint(0, "a_glitch");

    exp_frame[0]++;
    drive(0, 1'b0); hold(30 * BIT_CLKS); drive(0, 1'b1); hold(2 * BIT_CLKS);
    send_frame(0, 8'h7E, 1'b0, 2'b11);
    checkpoint(0, "a_break");

    for (int n = 0; n < 12; n++) begin
      int w;
      logic [1:0] stops;
      w = int'($urandom_range(0, 1));
      stops = 2'b11;
      if ($urandom_range(0, 4) == 0) stops[$urandom_range(0, (w == 0) ? 0 : 1)] = 1'b0;
      send_frame(w, 8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0), stops);
    end
    checkpoint(0, "a_rand");
    checkpoint(1, "b_rand");

    send_frame(0, 8'h42, 1'b0, 2'b11);
    send_frame(0, 8'hFF, 1'b0, 2'b11);
    checkpoint(0, "a_end");

    rdy_a = 1'b0;
    send_frame(0, 8'h33, 1'b0, 2'b11);
    drive(0, 1'b0); hold(3 * BIT_CLKS);
    drive(0, 1'b1);
    nrst = 1'b0;
    clear_model();
    hold(2);
    check_reset_state("midrst");
    nrst = 1'b1;
    rdy_a = 1'b1;
    hold(4);
    send_frame(0, 8'h5A, 1'b0, 2'b11);
    checkpoint(0, "a_post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/vl_uart_monitor.md
# vl_uart_monitor

Parametrised UART console monitor for the verilated SoC testbench: samples the SoC's TxD line, deframes characters with configurable data width, parity and stop bits, buffers accepted characters in a FIFO with a valid/ready output, and detects an end-of-simulation code. It is the successor to the fixed 8N1 receiver-plus-print logic in the verilated top. It adds error detection and counting, glitch rejection and output buffering, and makes printing optional.

## Interface
- DATA_BITS, 8 — character width, 5..8
- PARITY, 0 — 0 none, 1 odd, 2 even
- STOP_BITS, 1 — 1 or 2
- DIV, 27 — clk cycles per 16x oversample tick (115200 bps at 50 MHz)
- FIFO_DEPTH, 16 — power of two, 2..256
- END_CODE, 8'hFF — end-of-simulation character (low DATA_BITS bits compared)
- clk  in  1  clock, rising edge
- nrst  in  1  reset; one clock; reset is synchronous and active-low
- rxd  in  1  serial line, idle high, asynchronous to clk
- data_out  out  DATA_BITS  FIFO head character
- data_vld  out  1  FIFO non-empty
- data_rdy  in  1  consumer ready; pop when data_vld && data_rdy
- frame_err  out  1  one-cycle pulse, bad stop bit
- parity_err  out  1  one-cycle pulse, parity mismatch
- ovf_err  out  1  one-cycle pulse, character dropped because FIFO full
- err_cnt  out  16  saturating total of all three errors
- end_seen  out  1  sticky, END_CODE received

## Operation
- rxd is passed through a 2-FF synchroniser. Both flops reset to 1.
- Tick counter counts 0..DIV-1 and emits a tick on wrap. The counter is free-running except in IDLE, where it is held at 0 until a falling edge is seen.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK. Each bit lasts 16 ticks and is sampled at tick 8.
- IDLE → START on a synchronised falling edge.
- START: if the line is high at tick 8, this is a glitch: go to IDLE with no output. If low, go to DATA.
- DATA: shift in DATA_BITS bits, LSB first. Then go to PARITY if PARITY≠0, else to STOP.
- PARITY: compare the sampled bit with the odd/even parity of the data. Record a mismatch and go to STOP.
- STOP: sample STOP_BITS bits.
  - Any stop bit 0 → frame_err. Drop the character (framing takes priority over parity; one error per character). If the line is still low, go to BREAK; else go to IDLE.
  - Else if a parity mismatch was recorded → parity_err, drop the character.
  - Else accept the character.
- BREAK → IDLE once the synchronised line is high.
- Accepted character equal to END_CODE: set end_seen. The character is not pushed.
- Any other accepted character: push it if the FIFO is not full. If full, drop it and pulse ovf_err. A push in the same cycle as a pop while full succeeds, with no overflow.
- err_cnt increments once per error pulse and saturates at 16'hFFFF.
- Reset mid-frame: FSM returns to IDLE and the FIFO empties. The partial character is lost with no error.

## Timing
- Reset values: data_out 0, data_vld 0, all error pulses 0, err_cnt 0, end_seen 0.
- rxd to internal line: 2 cycles.
- Push occurs 1 cycle after the final stop-bit sample.
- data_vld rises the cycle after the push. Data is first-word-fall-through: data_out is valid whenever data_vld is high.
- Push into an empty FIFO with data_rdy high: the character is not visible or popped in the same cycle.
- Error pulses and end_seen assert in the same cycle the push would have occurred.
- Throughput: one character per frame time. The FIFO absorbs consumer stalls up to FIFO_DEPTH characters.

## Configuration
- VL_UART_MON_DISPLAY_EN defined:
  - A simulation-only block writes each popped character with $write("%c").
  - It calls $finish once end_seen is set and the FIFO is empty.
  - It prints a message for each error pulse.
- VL_UART_MON_DISPLAY_EN undefined: no system tasks; fully synthesizable; the consumer drives data_rdy.

## Structure
- Shared package/header vl_uart_mon_pkg:
  - FSM state encodings
  - PARITY_NONE/ODD/EVEN constants
  - OVRSAMP = 16 and MID_SAMPLE = 8
- Sub-module vl_uart_mon_fifo:
  - synchronous FIFO, parameters WIDTH and DEPTH
  - push/pop/full/empty
  - pointers one bit wider than the address for full/empty detection
- Top contains the synchroniser, tick generator, FSM, error/counter logic and the display block.

## Test plan
- 8N1, data_rdy=1, send 0x41 (432 clk/bit) → data_vld pulses with data_out=0x41; no errors; err_cnt=0.
- Send 0x55 with stop bit 0, then line high → frame_err one pulse; err_cnt=1; FIFO stays empty; FSM recovers and next byte 0x0A is received correctly.
- PARITY=2, send 0x03 with parity bit 1 → parity_err pulse; byte dropped. Resend with parity bit 0 → data_out=0x03.
- data_rdy=0, send 17 bytes 0x00..0x10 (DEPTH 16) → ovf_err on 0x10 only; then data_rdy=1 pops 0x00..0x0F in order.
- rxd low pulse of 5 ticks → no start, no output, no error. Break (rxd low 3 frames) → exactly one frame_err; first byte after line high is received.
- Send 0x42 then 0xFF → 0x42 output; end_seen=1; 0xFF not in FIFO. With VL_UART_MON_DISPLAY_EN, "B" is printed and then $finish.
